tx_sample_buffer: RTL and testbench

Clock-domain-local sample buffer that sits directly upstream of the CC1200 SPI top: it accepts 12-bit samples from a source over valid/ready, buffers them in a FIFO, and presents them on the SPI top's streaming port (TranSPIen / data2SPI / next_read). It primes before streaming, counts underruns and supports flush, so the SPI engine never stalls on source jitter.

---
 rtl/tx_sample_buffer_if.sv | 21 ++
 rtl/tx_sample_buffer.sv | 182 ++++++++++++++++++
 tb/tb_tx_sample_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_sample_buffer_if.sv
// ---------------------------------------------------------------------------
// TxSampleBufferIf
// Source-side sample handshake carried into tx_sample_buffer.
//
// Signals:
//   in_valid  source -> buffer   sample valid
//   in_data   source -> buffer   12-bit sample
//   in_ready  buffer -> source   buffer can accept (not full)
//
// Modports:
//   master  the sample source
//   slave   the buffer
// ---------------------------------------------------------------------------
interface tx_sample_buffer_if;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/tx_sample_buffer.sv
// ---------------------------------------------------------------------------
// tx_sample_buffer
// Sample FIFO sitting directly upstream of the CC1200 SPI top. It accepts
// 12-bit samples over valid/ready, waits until START_LEVEL samples are
// buffered, then presents them one at a time on data2SPI while TranSPIen
// is high. Each next_read pulse from the SPI top advances to the next
// sample. Reading from an empty FIFO while streaming is an underrun: it is
// flagged (sticky) and counted (saturating).
//
// Build option (macro TX_BUF_HOLD_LAST_EN):
//   defined     : on underrun data2SPI keeps the last valid sample
//   not defined : on underrun data2SPI becomes 12'h800 (mid-scale silence)
//
// Parameters:
//   DEPTH        FIFO depth in samples, power of two, 4..1024
//   START_LEVEL  fill level needed before streaming starts, 1..DEPTH
//   AW           pointer width, derived from DEPTH
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   Run          level, 1 = streaming enabled
//   Flush        one-cycle pulse, empties the FIFO and returns to IDLE
//   src          sample source handshake (slave modport)
//   TranSPIen    to SPI top GetDataEn, high while streaming
//   data2SPI     to SPI top GetData, current sample
//   next_read    from SPI top Next_data, consumes data2SPI
//   Level        FIFO occupancy, excludes the output register
//   Underrun     sticky underrun flag
//   UnderrunCnt  saturating underrun event counter
// ---------------------------------------------------------------------------
module tx_sample_buffer #(
    parameter int  DEPTH       = 64,
    parameter int  START_LEVEL = 16,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 Run,
    input  logic                 Flush,
    tx_sample_buffer_if.slave    src,
    output logic                 TranSPIen,
    output logic [11:0]          data2SPI,
    input  logic                 next_read,
    output logic [AW:0]          Level,
    output logic                 Underrun,
    output logic [15:0]          UnderrunCnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        LOAD,
        STREAM
    } state_t;

    state_t        state_q, state_d;

    // Pointers carry one extra bit so that full and empty stay distinguishable.
    logic [AW:0]   wrPtr_q, wrPtr_d;
    logic [AW:0]   rdPtr_q, rdPtr_d;
    logic [11:0]   data2SPI_q, data2SPI_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   underrunCnt_q, underrunCnt_d;

    logic [11:0]   mem [DEPTH];

    logic [AW:0]   level;
    logic          full;
    logic          push;
    logic          pop;
    logic          underrunEv;
    logic          streaming;

    assign level = wrPtr_q - rdPtr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign push  = src.in_valid && !full;

    assign src.in_ready = !full;
    assign Level        = level;
    assign data2SPI     = data2SPI_q;
    assign Underrun     = underrun_q;
    assign UnderrunCnt  = underrunCnt_q;
    assign TranSPIen    = streaming;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Run) state_d = PRIME;
            end
            PRIME: begin
                if (!Run) begin
                    state_d = IDLE;
                end else if (level >= (AW+1)'(START_LEVEL)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (Flush) state_d = IDLE;
    end

    // FSM outputs. LOAD is only reached with a non-empty FIFO, so its pop
    // needs no level check.
    always_comb begin
        streaming  = (state_q == STREAM);
        pop        = (state_q == LOAD) || (streaming && next_read && (level != '0));
        underrunEv = streaming && next_read && (level == '0);
    end

    // Datapath next-state: pointers, output register, underrun tracking.
    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        data2SPI_d    = data2SPI_q;
        underrun_d    = underrun_q;
        underrunCnt_d = underrunCnt_q;
        if (Flush) begin
            wrPtr_d       = '0;
            rdPtr_d       = '0;
            data2SPI_d    = 12'h000;
            underrun_d    = 1'b0;
            underrunCnt_d = 16'h0000;
        end else begin
            if (push) wrPtr_d = wrPtr_q + (AW+1)'(1);
            if (pop) begin
                rdPtr_d    = rdPtr_q + (AW+1)'(1);
                data2SPI_d = mem[rdPtr_q[AW-1:0]];
            end else if (underrunEv) begin
`ifdef TX_BUF_HOLD_LAST_EN
                data2SPI_d = data2SPI_q;
`else
                data2SPI_d = 12'h800;
`endif
            end
            if (underrunEv) begin
                underrun_d = 1'b1;
                if (underrunCnt_q != 16'hFFFF) underrunCnt_d = underrunCnt_q + 16'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            data2SPI_q    <= 12'h000;
            underrun_q    <= 1'b0;
            underrunCnt_q <= 16'h0000;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            data2SPI_q    <= data2SPI_d;
            underrun_q    <= underrun_d;
            underrunCnt_q <= underrunCnt_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !Flush) mem[wrPtr_q[AW-1:0]] <= src.in_data;
    end

endmodule

// File: tb/tb_tx_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_sample_buffer
// Directed bench for tx_sample_buffer (DEPTH=64, START_LEVEL=16). Inputs
// change 1 ns after each rising edge and outputs are sampled there too.
// Expected underrun data follows TX_BUF_HOLD_LAST_EN the same way the
// design does.
// ---------------------------------------------------------------------------
module tb_tx_sample_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Run;
    logic        Flush;
    logic        TranSPIen;
    logic [11:0] data2SPI;
    logic        nextRead;
    logic [6:0]  Level;
    logic        Underrun;
    logic [15:0] UnderrunCnt;

    int compareCount  = 0;
    int mismatchCount = 0;

    tx_sample_buffer_if srcIf ();

    tx_sample_buffer #(
        .DEPTH       (64),
        .START_LEVEL (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .Run         (Run),
        .Flush       (Flush),
        .src         (srcIf),
        .TranSPIen   (TranSPIen),
        .data2SPI    (data2SPI),
        .next_read   (nextRead),
        .Level       (Level),
        .Underrun    (Underrun),
        .UnderrunCnt (UnderrunCnt)
    );

    always #5 clk = ~clk;

`ifdef TX_BUF_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    // Drive one cycle of source/SPI inputs, then step past the next edge.
    task automatic applyStimulus(input logic v, input logic [11:0] d, input logic nr);
        srcIf.in_valid = v;
        srcIf.in_data  = d;
        nextRead       = nr;
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " TranSPIen"}, 32'(TranSPIen), 32'd0);
        checkOutput({tag, " data2SPI"}, 32'(data2SPI), 32'h000);
        checkOutput({tag, " Level"}, 32'(Level), 32'd0);
        checkOutput({tag, " in_ready"}, 32'(srcIf.in_ready), 32'd1);
        checkOutput({tag, " Underrun"}, 32'(Underrun), 32'd0);
        checkOutput({tag, " UnderrunCnt"}, 32'(UnderrunCnt), 32'd0);
    endtask

    initial begin
        logic [11:0] urData;
        rstn  = 1'b0;
        Run   = 1'b0;
        Flush = 1'b0;
        applyStimulus(1'b0, 12'h0, 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        rstn = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkResetValues("reset");

        // Prime with 15 samples: not enough to start.
        Run = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b0);
        for (int i = 1; i <= 15; i++) applyStimulus(1'b1, 12'(i), 1'b0);
        checkOutput("prime15 Level", 32'(Level), 32'd15);
        checkOutput("prime15 TranSPIen", 32'(TranSPIen), 32'd0);
        applyStimulus(1'b0, 12'h0, 1'b1);
        checkOutput("next_read in PRIME Level", 32'(Level), 32'd15);
        applyStimulus(1'b1, 12'h010, 1'b0);
        checkOutput("threshold TranSPIen", 32'(TranSPIen), 32'd0);
        checkOutput("threshold Level", 32'(Level), 32'd16);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("load TranSPIen", 32'(TranSPIen), 32'd0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("stream TranSPIen", 32'(TranSPIen), 32'd1);
        checkOutput("stream data2SPI", 32'(data2SPI), 32'h001);
        checkOutput("stream Level", 32'(Level), 32'd15);

        // Drain: each next_read presents the following sample.
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0, 12'h0, 1'b1);
            checkOutput("drain data2SPI", 32'(data2SPI), 32'(k + 1));
        end
        checkOutput("drained Level", 32'(Level), 32'd0);
        applyStimulus(1'b0, 12'h0, 1'b1);
        urData = HOLD_LAST ? 12'h010 : 12'h800;
        checkOutput("underrun flag", 32'(Underrun), 32'd1);
        checkOutput("underrun count", 32'(UnderrunCnt), 32'd1);
        checkOutput("underrun data2SPI", 32'(data2SPI), 32'(urData));
        checkOutput("underrun TranSPIen", 32'(TranSPIen), 32'd1);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("underrun flag sticky", 32'(Underrun), 32'd1);

        // Flush mid-stream with push and next_read in the same cycle.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 12'(12'h300 + i), 1'b0);
        checkOutput("preflush Level", 32'(Level), 32'd5);
        Flush = 1'b1;
        applyStimulus(1'b1, 12'h3FF, 1'b1);
        Flush = 1'b0;
        checkOutput("flush Level", 32'(Level), 32'd0);
        checkOutput("flush UnderrunCnt", 32'(UnderrunCnt), 32'd0);
        checkOutput("flush Underrun", 32'(Underrun), 32'd0);
        checkOutput("flush TranSPIen", 32'(TranSPIen), 32'd0);
        checkOutput("flush data2SPI", 32'(data2SPI), 32'h000);

        // Fill to DEPTH with Run low, then overfill.
        Run = 1'b0;
        applyStimulus(1'b0, 12'h0, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 12'(12'h100 + i), 1'b0);
        checkOutput("full Level", 32'(Level), 32'd64);
        checkOutput("full in_ready", 32'(srcIf.in_ready), 32'd0);
        applyStimulus(1'b1, 12'hFFF, 1'b0);
        checkOutput("overfill Level", 32'(Level), 32'd64);
        Run = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("full start TranSPIen", 32'(TranSPIen), 32'd1);
        checkOutput("full start data2SPI", 32'(data2SPI), 32'h100);
        checkOutput("full start Level", 32'(Level), 32'd63);
        applyStimulus(1'b1, 12'h0AA, 1'b1);
        checkOutput("push+pop Level", 32'(Level), 32'd63);
        checkOutput("push+pop data2SPI", 32'(data2SPI), 32'h101);

        // Drain to 10, then drop Run.
        repeat (53) applyStimulus(1'b0, 12'h0, 1'b1);
        checkOutput("level10 data2SPI", 32'(data2SPI), 32'h136);
        checkOutput("level10 Level", 32'(Level), 32'd10);
        Run = 1'b0;
        checkOutput("run fall TranSPIen before edge", 32'(TranSPIen), 32'd1);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("run fall TranSPIen", 32'(TranSPIen), 32'd0);
        checkOutput("run fall Level", 32'(Level), 32'd10);
        checkOutput("run fall data2SPI", 32'(data2SPI), 32'h136);
        Run = 1'b1;
        repeat (3) applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("reprime TranSPIen", 32'(TranSPIen), 32'd0);
        checkOutput("reprime Level", 32'(Level), 32'd10);

        // Top up to 16, restart, drain and saturate the underrun counter.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 12'(12'h200 + i), 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("restart TranSPIen", 32'(TranSPIen), 32'd1);
        checkOutput("restart data2SPI", 32'(data2SPI), 32'h137);
        checkOutput("restart Level", 32'(Level), 32'd15);
        repeat (15) applyStimulus(1'b0, 12'h0, 1'b1);
        checkOutput("redrain data2SPI", 32'(data2SPI), 32'h205);
        checkOutput("redrain Level", 32'(Level), 32'd0);
        repeat (65534) applyStimulus(1'b0, 12'h0, 1'b1);
        checkOutput("count FFFE", 32'(UnderrunCnt), 32'hFFFE);
        applyStimulus(1'b0, 12'h0, 1'b1);
        checkOutput("count FFFF", 32'(UnderrunCnt), 32'hFFFF);
        repeat (4) applyStimulus(1'b0, 12'h0, 1'b1);
        urData = HOLD_LAST ? 12'h205 : 12'h800;
        checkOutput("count saturated", 32'(UnderrunCnt), 32'hFFFF);
        checkOutput("saturated Underrun", 32'(Underrun), 32'd1);
        checkOutput("saturated data2SPI", 32'(data2SPI), 32'(urData));

        // Reset mid-stream with activity on every input.
        applyStimulus(1'b1, 12'h123, 1'b0);
        checkOutput("prereset Level", 32'(Level), 32'd1);
        rstn = 1'b0;
        applyStimulus(1'b1, 12'h456, 1'b1);
        rstn = 1'b1;
        checkResetValues("midreset");
        applyStimulus(1'b0, 12'h0, 1'b0);
        checkOutput("postreset TranSPIen", 32'(TranSPIen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
